// File: rtl/pool2x2_stream_if.sv
// pool2x2_stream_if: sample stream in, pooled stream out.
interface pool2x2_stream_if #(parameter int DATA_W = 8);
    logic                     in_valid;
    logic                     in_sof;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_eof;
    logic signed [DATA_W-1:0] out_data;
    modport master(output in_valid, in_sof, in_data, input out_valid, out_eof, out_data);
    modport slave(input in_valid, in_sof, in_data, output out_valid, out_eof, out_data);
endinterface

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming signed 2x2 max-pool over a raster-order feature map.
module pool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic clk,
    input logic rst,
    pool2x2_stream_if.slave s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;
    logic [CW-1:0] col, pos_col, nxt_col;
    logic [RW-1:0] row, pos_row, nxt_row;
    logic [LW-1:0] li;
    logic last_col, fire, out_valid_q, out_eof_q;
    logic signed [DATA_W-1:0] hold, hmax, lb_q, pmax, out_data_q;
    logic signed [DATA_W-1:0] lb [0:(1<<LW)-1];
    // in_sof relocates the current sample to (0,0) without waiting for a counter update
    always_comb begin
        pos_col  = s.in_sof ? '0 : col;
        pos_row  = s.in_sof ? '0 : row;
        last_col = pos_col == CW'(IMG_W - 1);
        nxt_col  = last_col ? '0 : pos_col + CW'(1);
        nxt_row  = !last_col ? pos_row : pos_row == RW'(IMG_H - 1) ? '0 : pos_row + RW'(1);
        li       = LW'(pos_col >> 1);
        hmax     = s.in_data > hold ? s.in_data : hold;
        lb_q     = lb[li];
        pmax     = hmax > lb_q ? hmax : lb_q;
        fire     = s.in_valid & pos_col[0] & pos_row[0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            hold        <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= fire;
            out_eof_q   <= fire && last_col && pos_row == RW'(IMG_H - 1);
            if (fire) out_data_q <= pmax;
            if (s.in_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                if (!pos_col[0]) hold <= s.in_data;
            end
        end
    end
    // line buffer needs no reset: each even row writes every entry before the odd row reads it
    always_ff @(posedge clk) begin
        if (!rst && s.in_valid && pos_col[0] && !pos_row[0]) lb[li] <= hmax;
    end
    assign s.out_valid = out_valid_q;
    assign s.out_eof   = out_eof_q;
    assign s.out_data  = out_data_q;
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: table vectors, corner sequences and random traffic against a frame-array model.
module tb_pool2x2_stream;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    typedef struct {
        logic v;
        logic s;
        logic signed [DW-1:0] d;
        logic ev;
        logic signed [DW-1:0] ed;
        logic ee;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pool2x2_stream_if #(.DATA_W(DW)) bus ();
    pool2x2_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .s(bus));
    int n_chk = 0, n_fail = 0, pulses = 0;
    int eof_pos[$];
    logic signed [DW-1:0] pix [H][W];
    int mr = 0, mc = 0;
    logic m_valid = 1'b0, m_eof = 1'b0;
    logic signed [DW-1:0] m_data = '0;
    vec_t tbl [22];

    function automatic logic signed [DW-1:0] mx(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        return a > b ? a : b;
    endfunction

    // model: place each sample into a frame array, pool the 2x2 block when its last pixel arrives
    task automatic model(input logic v, input logic s, input logic signed [DW-1:0] d);
        m_valid = 1'b0;
        m_eof   = 1'b0;
        if (!v) return;
        if (s) begin mr = 0; mc = 0; end
        pix[mr][mc] = d;
        if (mr % 2 == 1 && mc % 2 == 1) begin
            m_valid = 1'b1;
            m_data  = mx(mx(pix[mr-1][mc-1], pix[mr-1][mc]), mx(pix[mr][mc-1], pix[mr][mc]));
            m_eof   = (mr == H - 1) && (mc == W - 1);
        end
        mc++;
        if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
    endtask

    task automatic step(input logic v, input logic s, input logic signed [DW-1:0] d);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        model(v, s, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic ev, input logic signed [DW-1:0] ed, input logic ee);
        n_chk++;
        if (bus.out_valid !== ev || bus.out_data !== ed || bus.out_eof !== ee) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b data=%0d eof=%0b, expected valid=%0b data=%0d eof=%0b",
                     nm, bus.out_valid, bus.out_data, bus.out_eof, ev, ed, ee);
        end
        if (bus.out_valid === 1'b1) pulses++;
        if (bus.out_eof === 1'b1) eof_pos.push_back(pulses);
    endtask

    task automatic mstep(input string nm, input logic v, input logic s, input logic signed [DW-1:0] d);
        step(v, s, d);
        chk(nm, m_valid, m_data, m_eof);
    endtask

    task automatic cnt(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        mr = 0; mc = 0; m_valid = 1'b0; m_eof = 1'b0; m_data = '0;
    endtask

    task automatic clear_counts();
        pulses = 0;
        eof_pos.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, i == 0, DW'(i), i == 5 || i == 7 || i == 13 || i == 15,
                       DW'(i < 5 ? 0 : i < 7 ? 5 : i < 13 ? 7 : i < 15 ? 13 : 15), i == 15};
        tbl[16] = '{1'b1, 1'b1, -8'sd3, 1'b0, 8'sd15, 1'b0};
        tbl[17] = '{1'b1, 1'b0, -8'sd1, 1'b0, 8'sd15, 1'b0};
        tbl[18] = '{1'b1, 1'b0,  8'sd0, 1'b0, 8'sd15, 1'b0};
        tbl[19] = '{1'b1, 1'b0,  8'sd0, 1'b0, 8'sd15, 1'b0};
        tbl[20] = '{1'b1, 1'b0, -8'sd8, 1'b0, 8'sd15, 1'b0};
        tbl[21] = '{1'b1, 1'b0, -8'sd2, 1'b1, -8'sd1, 1'b0};
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("reset", 1'b0, '0, 1'b0);
        rst = 1'b0;

        // raster 0..15 frame, then a signed block
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            chk($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].ee);
        end

        // same frame with three idle cycles between samples
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            mstep("gaps", 1'b1, i == 0, DW'(i));
            for (int g = 0; g < 3; g++) mstep("gaps_idle", 1'b0, 1'b0, '0);
        end
        cnt("gaps_pulses", pulses, 4);
        cnt("gaps_eofs", eof_pos.size(), 1);

        // reset in row 1, new frame without in_sof
        for (int i = 0; i < 6; i++) mstep("pre_rst", 1'b1, i == 0, DW'(i + 20));
        #2 rst = 1'b1;
        #1 chk("async_rst", 1'b0, '0, 1'b0);
        @(negedge clk);
        model_reset();
        chk("rst_hold", 1'b0, '0, 1'b0);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 16; i++) mstep("post_rst", 1'b1, 1'b0, DW'(i * 3 - 20));
        mstep("post_rst_idle", 1'b0, 1'b0, '0);
        cnt("post_rst_pulses", pulses, 4);
        cnt("post_rst_eofs", eof_pos.size(), 1);

        // in_sof mid-frame after 6 samples
        clear_counts();
        for (int i = 0; i < 6; i++) mstep("partial", 1'b1, i == 0, DW'($urandom));
        for (int i = 0; i < 16; i++) mstep("restart", 1'b1, i == 0, DW'($urandom));
        mstep("restart_idle", 1'b0, 1'b0, '0);
        cnt("restart_pulses", pulses, 5);
        cnt("restart_eofs", eof_pos.size(), 1);

        // back-to-back frames
        clear_counts();
        for (int i = 0; i < 32; i++) mstep("b2b", 1'b1, i == 0 || i == 16, DW'($urandom));
        mstep("b2b_idle", 1'b0, 1'b0, '0);
        cnt("b2b_pulses", pulses, 8);
        cnt("b2b_eof_pos", eof_pos.size() == 2 ? eof_pos[0] * 10 + eof_pos[1] : -1, 48);

        // random traffic with gaps, stray in_sof and occasional restarts
        for (int i = 0; i < 800; i++) begin
            logic v, s;
            v = $urandom_range(0, 3) != 0;
            s = v ? $urandom_range(0, 63) == 0 : $urandom_range(0, 7) == 0;
            mstep("rand", v, s, DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
